// File: rtl/video_mode_sequencer.sv
// video_mode_sequencer: applies menu video-mode requests to the mixer only at
// frame boundaries, blanking the screen around changes that disturb sync.
module video_mode_sequencer #(
  parameter int unsigned MUTE_FRAMES = 4,
  parameter logic [23:0] VS_TIMEOUT  = 24'd3000000
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       VSync,
  input  logic [1:0] scanlines_req,
  input  logic       sd_disable_req,
  input  logic       hq2x_req,
  input  logic       ypbpr_req,
  input  logic       ypbpr_full_req,
  output logic [1:0] scanlines,
  output logic       scandoubler_disable,
  output logic       hq2x,
  output logic       ypbpr,
  output logic       ypbpr_full,
  output logic       blank,
  output logic       busy,
  output logic       no_vsync
);

  localparam int unsigned WD_W = 24;
  localparam int unsigned MC_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    MUTE = 2'd2
  } state_t;

  state_t            state;
  logic              old_vs;
  logic [WD_W-1:0]   wd_cnt;
  logic [MC_W-1:0]   mute_cnt;

  logic vs_fall_c;
  logic wd_timeout_c;
  logic fe_c;
  logic sync_diff_c;

  // Frame event: real VSync fall or watchdog substitute; both at once is one event
  assign vs_fall_c    = old_vs & ~VSync;
  assign wd_timeout_c = (wd_cnt == (VS_TIMEOUT - 24'd1));
  assign fe_c         = vs_fall_c | wd_timeout_c;

  // Any request that changes monitor timing and is not yet applied
  assign sync_diff_c = (sd_disable_req != scandoubler_disable) |
                       (hq2x_req       != hq2x) |
                       (ypbpr_req      != ypbpr);

  // VSync edge history and missing-VSync watchdog
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      old_vs   <= 1'b0;
      wd_cnt   <= '0;
      no_vsync <= 1'b0;
    end else begin
      old_vs <= VSync;
      if (vs_fall_c) begin
        wd_cnt   <= '0;
        no_vsync <= 1'b0;
      end else if (wd_timeout_c) begin
        wd_cnt   <= '0;
        no_vsync <= 1'b1;
      end else begin
        wd_cnt <= wd_cnt + WD_W'(1);
      end
    end
  end

  // Cosmetic settings need no blanking; they follow requests at every frame event
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      scanlines  <= 2'd0;
      ypbpr_full <= 1'b0;
    end else if (fe_c) begin
      scanlines  <= scanlines_req;
      ypbpr_full <= ypbpr_full_req;
    end
  end

  // Sync-group sequencing: blank, apply at frame event, hold black for the mute window
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state               <= MUTE;
      mute_cnt            <= MC_W'(MUTE_FRAMES);
      blank               <= 1'b1;
      busy                <= 1'b1;
      scandoubler_disable <= 1'b0;
      hq2x                <= 1'b0;
      ypbpr               <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (sync_diff_c) begin
            state <= PRE;
            blank <= 1'b1;
            busy  <= 1'b1;
          end
        end
        PRE: begin
          if (fe_c) begin
            scandoubler_disable <= sd_disable_req;
            hq2x                <= hq2x_req;
            ypbpr               <= ypbpr_req;
            mute_cnt            <= MC_W'(MUTE_FRAMES);
            state               <= MUTE;
          end
        end
        MUTE: begin
          if (sync_diff_c) begin
            state <= PRE;
          end else if (fe_c) begin
            mute_cnt <= mute_cnt - MC_W'(1);
            if (mute_cnt == MC_W'(1)) begin
              state <= IDLE;
              blank <= 1'b0;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state <= MUTE;
          blank <= 1'b1;
          busy  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_video_mode_sequencer.sv
// Directed bench for video_mode_sequencer with hand-computed expectations.
module tb_video_mode_sequencer;

  logic       clk_sys;
  logic       reset_n;
  logic       VSync;
  logic [1:0] scanlines_req;
  logic       sd_disable_req;
  logic       hq2x_req;
  logic       ypbpr_req;
  logic       ypbpr_full_req;
  logic [1:0] scanlines;
  logic       scandoubler_disable;
  logic       hq2x;
  logic       ypbpr;
  logic       ypbpr_full;
  logic       blank;
  logic       busy;
  logic       no_vsync;

  int tests  = 0;
  int failed = 0;

  video_mode_sequencer #(
    .MUTE_FRAMES(4),
    .VS_TIMEOUT (24'd100)
  ) dut (
    .clk_sys            (clk_sys),
    .reset_n            (reset_n),
    .VSync              (VSync),
    .scanlines_req      (scanlines_req),
    .sd_disable_req     (sd_disable_req),
    .hq2x_req           (hq2x_req),
    .ypbpr_req          (ypbpr_req),
    .ypbpr_full_req     (ypbpr_full_req),
    .scanlines          (scanlines),
    .scandoubler_disable(scandoubler_disable),
    .hq2x               (hq2x),
    .ypbpr              (ypbpr),
    .ypbpr_full         (ypbpr_full),
    .blank              (blank),
    .busy               (busy),
    .no_vsync           (no_vsync)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  // Advance n rising edges and settle 1 time unit past the last one
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk_sys);
    end
    #1;
  endtask

  // Four-cycle VSync pulse; returns just after the edge that sees the fall
  task automatic vs_fall();
    VSync = 1'b1;
    cyc(3);
    VSync = 1'b0;
    cyc(1);
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset_n        = 1'b0;
    VSync          = 1'b0;
    scanlines_req  = 2'd0;
    sd_disable_req = 1'b0;
    hq2x_req       = 1'b0;
    ypbpr_req      = 1'b0;
    ypbpr_full_req = 1'b0;

    // Reset state
    cyc(3);
    check("rst_blank",    8'(blank), 8'd1);
    check("rst_busy",     8'(busy), 8'd1);
    check("rst_scan",     8'(scanlines), 8'd0);
    check("rst_sd",       8'(scandoubler_disable), 8'd0);
    check("rst_no_vsync", 8'(no_vsync), 8'd0);
    reset_n = 1'b1;

    // Startup mute: blank until the 4th fall
    for (int i = 1; i <= 3; i++) begin
      cyc(30);
      vs_fall();
      check("start_blank", 8'(blank), 8'd1);
      check("start_busy",  8'(busy), 8'd1);
    end
    cyc(30);
    vs_fall();
    check("start_end_blank", 8'(blank), 8'd0);
    check("start_end_busy",  8'(busy), 8'd0);
    check("start_end_sd",    8'(scandoubler_disable), 8'd0);

    // Cosmetic change mid-frame: applied at next fall, no blanking
    cyc(10);
    scanlines_req  = 2'd2;
    ypbpr_full_req = 1'b1;
    cyc(15);
    check("cos_wait_scan",  8'(scanlines), 8'd0);
    check("cos_wait_busy",  8'(busy), 8'd0);
    cyc(5);
    vs_fall();
    check("cos_scan",  8'(scanlines), 8'd2);
    check("cos_yfull", 8'(ypbpr_full), 8'd1);
    check("cos_blank", 8'(blank), 8'd0);
    check("cos_busy",  8'(busy), 8'd0);

    // Sync change from IDLE: blank next cycle, apply at fall, 4-frame mute
    cyc(10);
    sd_disable_req = 1'b1;
    cyc(1);
    check("sd_pre_blank", 8'(blank), 8'd1);
    check("sd_pre_busy",  8'(busy), 8'd1);
    check("sd_pre_val",   8'(scandoubler_disable), 8'd0);
    cyc(20);
    vs_fall();
    check("sd_apply",       8'(scandoubler_disable), 8'd1);
    check("sd_apply_blank", 8'(blank), 8'd1);
    for (int i = 1; i <= 3; i++) begin
      cyc(30);
      vs_fall();
      check("sd_mute_blank", 8'(blank), 8'd1);
    end
    cyc(30);
    vs_fall();
    check("sd_end_blank", 8'(blank), 8'd0);
    check("sd_end_busy",  8'(busy), 8'd0);

    // New request during MUTE at counter 2 restarts the sequence
    cyc(10);
    hq2x_req = 1'b1;
    cyc(20);
    vs_fall();
    check("hq_apply1", 8'(hq2x), 8'd1);
    for (int i = 1; i <= 2; i++) begin
      cyc(30);
      vs_fall();
    end
    cyc(5);
    hq2x_req = 1'b0;
    cyc(1);
    check("hq_repre_blank", 8'(blank), 8'd1);
    check("hq_repre_busy",  8'(busy), 8'd1);
    check("hq_repre_val",   8'(hq2x), 8'd1);
    cyc(20);
    vs_fall();
    check("hq_apply2", 8'(hq2x), 8'd0);
    check("hq_apply2_blank", 8'(blank), 8'd1);
    for (int i = 1; i <= 3; i++) begin
      cyc(30);
      vs_fall();
      check("hq_mute_blank", 8'(blank), 8'd1);
    end
    cyc(30);
    vs_fall();
    check("hq_end_blank", 8'(blank), 8'd0);

    // Request arriving on the fe cycle in IDLE only enters PRE
    cyc(30);
    VSync = 1'b1;
    cyc(3);
    VSync = 1'b0;
    sd_disable_req = 1'b0;
    cyc(1);
    check("coinc_not_applied", 8'(scandoubler_disable), 8'd1);
    check("coinc_blank",       8'(blank), 8'd1);
    cyc(30);
    vs_fall();
    check("coinc_apply", 8'(scandoubler_disable), 8'd0);
    for (int i = 1; i <= 3; i++) begin
      cyc(30);
      vs_fall();
    end
    check("coinc_mute_blank", 8'(blank), 8'd1);
    cyc(30);
    vs_fall();
    check("coinc_end_blank", 8'(blank), 8'd0);

    // VSync stalled low: watchdog events every 100 cycles drive the sequence
    ypbpr_req = 1'b1;
    cyc(99);
    check("wd_pre_novs",  8'(no_vsync), 8'd0);
    check("wd_pre_ypbpr", 8'(ypbpr), 8'd0);
    check("wd_pre_blank", 8'(blank), 8'd1);
    cyc(1);
    check("wd_novs",  8'(no_vsync), 8'd1);
    check("wd_ypbpr", 8'(ypbpr), 8'd1);
    cyc(300);
    check("wd_mute_blank", 8'(blank), 8'd1);
    cyc(99);
    check("wd_last_blank", 8'(blank), 8'd1);
    cyc(1);
    check("wd_end_blank", 8'(blank), 8'd0);
    check("wd_end_busy",  8'(busy), 8'd0);
    cyc(5);
    vs_fall();
    check("wd_clear_novs", 8'(no_vsync), 8'd0);
    check("wd_keep_ypbpr", 8'(ypbpr), 8'd1);

    // Asynchronous reset while in PRE
    cyc(10);
    sd_disable_req = 1'b1;
    cyc(1);
    check("ar_pre_blank", 8'(blank), 8'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("ar_ypbpr", 8'(ypbpr), 8'd0);
    check("ar_scan",  8'(scanlines), 8'd0);
    check("ar_yfull", 8'(ypbpr_full), 8'd0);
    check("ar_blank", 8'(blank), 8'd1);
    check("ar_busy",  8'(busy), 8'd1);
    scanlines_req  = 2'd0;
    sd_disable_req = 1'b0;
    ypbpr_req      = 1'b0;
    ypbpr_full_req = 1'b0;
    cyc(2);
    reset_n = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      cyc(30);
      vs_fall();
      check("ar_mute_blank", 8'(blank), 8'd1);
    end
    cyc(30);
    vs_fall();
    check("ar_end_blank", 8'(blank), 8'd0);
    check("ar_end_busy",  8'(busy), 8'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
